// File: rtl/dcmi_ahb_slv_if.sv
// rtl/dcmi_ahb_slv_if.sv - AHB-Lite slave bundle plus DCMI internal register bus
// Purpose: groups the AHB-Lite transfer signals and the single-cycle register-bus
//          strobes that dcmi_ahb_slv translates between.
// Signals:
//   hsel, htrans[1:0], hwrite, hsize[2:0], haddr[5:0], hwdata[31:0], hready  - AHB request side
//   hreadyout, hresp, hrdata[31:0]                                          - AHB response side
//   ahb_bus_sel, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr[3:0],
//   ahb_bus_bsel[3:0], ahb_bus_wdata[31:0]                                   - register strobes
//   ahb_bus_rdata[31:0]                                                      - register read data
// Modports:
//   slave  - the front-end itself
//   master - its environment: the AHB master/interconnect together with the register block
interface dcmi_ahb_slv_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [5:0]  haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  logic        ahb_bus_sel;
  logic        ahb_bus_wr;
  logic        ahb_bus_rd;
  logic [3:0]  ahb_bus_addr;
  logic [3:0]  ahb_bus_bsel;
  logic [31:0] ahb_bus_wdata;
  logic [31:0] ahb_bus_rdata;

  modport slave (
    input  hsel, htrans, hwrite, hsize, haddr, hwdata, hready, ahb_bus_rdata,
    output hreadyout, hresp, hrdata,
    output ahb_bus_sel, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel, ahb_bus_wdata
  );

  modport master (
    output hsel, htrans, hwrite, hsize, haddr, hwdata, hready, ahb_bus_rdata,
    input  hreadyout, hresp, hrdata,
    input  ahb_bus_sel, ahb_bus_wr, ahb_bus_rd, ahb_bus_addr, ahb_bus_bsel, ahb_bus_wdata
  );
endinterface

// File: rtl/dcmi_ahb_slv.sv
// rtl/dcmi_ahb_slv.sv - AHB-Lite slave front-end for the DCMI register file
// Purpose: converts AHB-Lite address/data-phase transfers into single-cycle
//          register-bus strobes, decodes byte lanes, checks alignment and range,
//          and answers illegal transfers with a two-cycle ERROR response.
// Optional feature macro: DCMI_AHB_RD_WAIT_EN
//   defined   - reads take one wait state and hrdata comes from a capture register
//   undefined - all reads are zero-wait, hrdata is ahb_bus_rdata gated by the read strobe
// Parameters:
//   NUM_REGS - number of implemented 32-bit registers; word index >= NUM_REGS is unmapped
// Ports:
//   hclk - AHB clock
//   rstn - asynchronous active-low reset
//   bus  - dcmi_ahb_slv_if.slave (AHB-Lite slave signals and internal register bus)
module dcmi_ahb_slv #(
  parameter int NUM_REGS = 5
) (
  input  logic          hclk,
  input  logic          rstn,
  dcmi_ahb_slv_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2,
    ST_RDW
  } state_t;

  state_t      state_q;
  logic        sel_q;
  logic        wr_q;
  logic        rd_q;
  logic [3:0]  addr_q;
  logic [3:0]  bsel_q;
  logic        hreadyout_q;
  logic        hresp_q;
`ifdef DCMI_AHB_RD_WAIT_EN
  logic [31:0] rdata_q;
`endif

  // Address-phase decode; these are the values latched on an accepting edge.
  logic        accept_d;
  logic [3:0]  bsel_d;
  logic        err_d;

  always_comb begin
    accept_d = bus.hsel & bus.htrans[1] & bus.hready;
    bsel_d   = 4'b0000;
    err_d    = 1'b0;
    case (bus.hsize)
      3'b000: bsel_d = 4'b0001 << bus.haddr[1:0];
      3'b001: begin
        bsel_d = bus.haddr[1] ? 4'b1100 : 4'b0011;
        err_d  = bus.haddr[0];
      end
      3'b010: begin
        bsel_d = 4'b1111;
        err_d  = |bus.haddr[1:0];
      end
      default: err_d = 1'b1;
    endcase
    if (int'({28'd0, bus.haddr[5:2]}) >= NUM_REGS) begin
      err_d = 1'b1;
    end
  end

  // All outputs except hrdata/ahb_bus_wdata are registered here, so every
  // strobe is a clean single-cycle pulse that cannot glitch with address decode.
  always_ff @(posedge hclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 4'd0;
      bsel_q      <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
`ifdef DCMI_AHB_RD_WAIT_EN
      rdata_q     <= 32'd0;
`endif
    end else begin
      // Strobes default low: they exist only in the cycle right after an accept.
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 4'd0;
      bsel_q      <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;

      if (state_q == ST_ERR1) begin
        // Second ERROR cycle is unconditional; hready was low so nothing was accepted.
        state_q <= ST_ERR2;
        hresp_q <= 1'b1;
      end
`ifdef DCMI_AHB_RD_WAIT_EN
      else if ((state_q == ST_DATA) && rd_q) begin
        // Read strobe cycle: sample the register while its address is still driven.
        state_q <= ST_RDW;
        rdata_q <= bus.ahb_bus_rdata;
      end
`endif
      else if (accept_d) begin
        if (err_d) begin
          state_q     <= ST_ERR1;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b1;
        end else begin
          state_q <= ST_DATA;
          sel_q   <= 1'b1;
          wr_q    <= bus.hwrite;
          rd_q    <= ~bus.hwrite;
          addr_q  <= bus.haddr[5:2];
          bsel_q  <= bsel_d;
`ifdef DCMI_AHB_RD_WAIT_EN
          // Reads stall their strobe cycle; writes stay zero-wait.
          hreadyout_q <= bus.hwrite;
`endif
        end
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.hreadyout     = hreadyout_q;
  assign bus.hresp         = hresp_q;
  assign bus.ahb_bus_sel   = sel_q;
  assign bus.ahb_bus_wr    = wr_q;
  assign bus.ahb_bus_rd    = rd_q;
  assign bus.ahb_bus_addr  = addr_q;
  assign bus.ahb_bus_bsel  = bsel_q;
  assign bus.ahb_bus_wdata = bus.hwdata;

`ifdef DCMI_AHB_RD_WAIT_EN
  assign bus.hrdata = (state_q == ST_RDW) ? rdata_q : 32'd0;
`else
  assign bus.hrdata = rd_q ? bus.ahb_bus_rdata : 32'd0;
`endif

endmodule
